sya_deskew: RTL
===============

Name: sya_deskew

Overview:
- Output-side realigner for the systolic array. Lane j of the array emits element k of a result row j beats after lane 0, so each row arrives skewed.
- Each lane is buffered independently. A full aligned row vector is released once every lane holds its element for that row.
- Counterpart of the input-side skew buffer. Sits between the SYA result lanes and the result writeback path.

Parameters:
- DATA_WIDTH, 8, bits per lane element
- SIDE_LEN, 16, number of lanes (array side length)
- DEPTH, 32, rows buffered per lane; power of two and >= 2*SIDE_LEN
- ADDR_WIDTH, $clog2(DEPTH), lane buffer address width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear; empties all lanes, drops the output register
- din  input  SIDE_LEN*DATA_WIDTH  lane data, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
- din_vld  input  SIDE_LEN  per-lane write valid
- din_rdy  output  SIDE_LEN  per-lane ready; bit j = (cnt[j] < DEPTH)
- dout  output  SIDE_LEN*DATA_WIDTH  aligned row
- dout_vld  output  1  row valid
- dout_rdy  input  1  downstream accept
- ovf_err  output  1  sticky flag: some din_vld[j] was asserted while din_rdy[j]=0

Behaviour:
- Reset (rst=1, async): all wp[j], rd_ptr and cnt[j] go to 0. dout=0, dout_vld=0, din_rdy=all ones, ovf_err=0.
- clr has the same effect, taken at the clock edge. If clr and rst are both asserted, rst wins. clr has priority over every write and pop in the same cycle.
- Per lane j, write:
  - A write happens when din_vld[j] & din_rdy[j].
  - mem[j][wp[j]] <= din[j]; wp[j] increments and wraps modulo DEPTH.
  - Lanes write independently; any subset of lanes may write in a cycle.
- Shared read pointer: row_avail = AND over j of (cnt[j] != 0).
- Pop:
  - pop = row_avail & (!dout_vld | dout_rdy).
  - On pop: dout <= {mem[j][rd_ptr]} for all j, dout_vld <= 1. rd_ptr increments and wraps, and every cnt[j] decrements.
  - If dout_vld & dout_rdy & !row_avail, then dout_vld <= 0 and dout holds its last value.
- Count update per lane:
  - write only: cnt[j] + 1
  - pop only: cnt[j] - 1
  - write and pop together: unchanged
  - cnt[j] has ADDR_WIDTH+1 bits and never exceeds DEPTH.
- Latency: the last lane of a row is written at edge t, cnt updates at t, pop happens at edge t+1, and dout_vld is high after t+1. That is one cycle from the completing write to a visible row.
- Throughput: one row per cycle when dout_rdy is held high.
- Full lane:
  - din_rdy[j]=0 and the write is dropped; other lanes are unaffected.
  - ovf_err sets and stays set until rst or clr.
  - A write to a full lane that coincides with a pop is still refused, because din_rdy is registered-count based with no bypass.
- Empty lane: blocks row release for all lanes; no partial rows are ever output.
- Backpressure: while dout_vld=1 and dout_rdy=0, dout and dout_vld are stable, and lanes keep filling up to DEPTH.
- Wrap-around: the wp and rd_ptr wrap is transparent; ordering is preserved per lane.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, SIDE_LEN, DEPTH defaults
  - lane_t = logic [DATA_WIDTH-1:0]
  - row_t = lane_t [SIDE_LEN-1:0]
- One sub-module, sya_deskew_lane:
  - Single-lane storage array, wp, cnt, din_rdy.
  - Inputs: wr, pop. Outputs: nonempty, rdata at a shared rd_ptr.
  - Instantiated SIDE_LEN times.
- The top level owns rd_ptr, row_avail, the output register and ovf_err.

Test Plan:
- Reset/idle: rst pulse mid-stream -> dout_vld=0, din_rdy=all ones, ovf_err=0, dout=0 immediately, without waiting for a clock edge.
- Skewed row (SIDE_LEN=4): lane j sends 8'h10+j at cycle j, with dout_rdy=1 -> one row {13,12,11,10} with dout_vld=1 exactly one cycle after the lane-3 write, then dout_vld drops.
- Streaming: skewed stream of 8 rows, each lane delayed j cycles -> 8 consecutive aligned rows in order, one per cycle once lane 3 has started.
- Backpressure/full (DEPTH=8): dout_rdy=0, lane 0 writes 9 values -> din_rdy[0]=0 after 8, 9th write dropped, ovf_err=1. Release dout_rdy -> rows drain in order; ovf_err stays 1 until clr.
- Simultaneous write and pop: steady state with cnt[0]=3, write and pop in the same cycle -> cnt[0] stays 3, no data lost or duplicated.
- clr mid-stream with 5 rows buffered and dout_vld=1 -> the next cycle has dout_vld=0 and all cnt=0; the next skewed row is output correctly starting from rd_ptr 0.

Source files
------------

// File: rtl/sya_deskew_pkg.sv
// rtl/sya_deskew_pkg.sv - shared defaults and element types for the systolic-array output deskew buffer
package sya_deskew_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SIDE_LEN   = 16;
  localparam int DEF_DEPTH      = 32;

  typedef logic [DEF_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_SIDE_LEN-1:0]  row_t;

endpackage

// File: rtl/sya_deskew_if.sv
// rtl/sya_deskew_if.sv - lane-side write bus and aligned-row read bus of the deskew buffer
interface sya_deskew_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SIDE_LEN   = 16
);

  logic                           clr;
  logic [SIDE_LEN*DATA_WIDTH-1:0] din;
  logic [SIDE_LEN-1:0]            din_vld;
  logic [SIDE_LEN-1:0]            din_rdy;
  logic [SIDE_LEN*DATA_WIDTH-1:0] dout;
  logic                           dout_vld;
  logic                           dout_rdy;
  logic                           ovf_err;

  modport master (
    output clr, din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld, ovf_err
  );

  modport slave (
    input  clr, din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld, ovf_err
  );

endinterface

// File: rtl/sya_deskew_lane.sv
// rtl/sya_deskew_lane.sv - one lane buffer: storage, write pointer and occupancy count
module sya_deskew_lane
  import sya_deskew_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  nonempty,
  output logic                  rdy
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH:0]   cnt;

  assign rdy      = (cnt < CNT_FULL);
  assign nonempty = (cnt != '0);
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + ADDR_WIDTH'(1);
      case ({wr, pop})
        2'b10:   cnt <= cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_WIDTH+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr && !clr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/sya_deskew.sv
// rtl/sya_deskew.sv - realigns skewed systolic-array result lanes into whole row vectors
module sya_deskew
  import sya_deskew_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIDE_LEN   = DEF_SIDE_LEN,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  sya_deskew_if.slave bus
);

  logic [ADDR_WIDTH-1:0]          rd_ptr;
  logic [SIDE_LEN-1:0]            nonempty;
  logic [SIDE_LEN-1:0]            rdy;
  logic [SIDE_LEN-1:0]            wr;
  logic [SIDE_LEN*DATA_WIDTH-1:0] rrow;
  logic [SIDE_LEN*DATA_WIDTH-1:0] dout_q;
  logic                           dout_vld_q;
  logic                           ovf_q;
  logic                           row_avail;
  logic                           pop;

  assign row_avail = &nonempty;
  assign pop       = row_avail & (!dout_vld_q | bus.dout_rdy);
  assign wr        = bus.din_vld & rdy;

  for (genvar j = 0; j < SIDE_LEN; j++) begin : g_lane
    sya_deskew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.clr),
      .wr       (wr[j]),
      .wdata    (bus.din[j*DATA_WIDTH +: DATA_WIDTH]),
      .pop      (pop),
      .rd_ptr   (rd_ptr),
      .rdata    (rrow[j*DATA_WIDTH +: DATA_WIDTH]),
      .nonempty (nonempty[j]),
      .rdy      (rdy[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.clr) begin
      rd_ptr     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (pop) begin
        dout_q     <= rrow;
        dout_vld_q <= 1'b1;
        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
      end else if (dout_vld_q && bus.dout_rdy) begin
        dout_vld_q <= 1'b0;
      end
      // A refused write on any lane is remembered until reset or clear.
      ovf_q <= ovf_q | (|(bus.din_vld & ~rdy));
    end
  end

  assign bus.din_rdy  = rdy;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.ovf_err  = ovf_q;

endmodule
